// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand bundle for the digit-serial magnitude comparator.
interface seq_mag_comparator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             AequalsB;
  logic             AgreaterB;
  logic             AlessB;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, AequalsB, AgreaterB, AlessB
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, AequalsB, AgreaterB, AlessB
  );
endinterface

// File: rtl/seq_mag_comparator.sv
// Digit-serial MSB-first magnitude comparator with early termination on the
// first differing digit; signed operands are mapped to offset binary on capture.
module seq_mag_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  seq_mag_comparator_if.slave bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_LOAD = CW'(N - 1);

  typedef enum logic {IDLE, COMPARE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [DIGIT-1:0] dig_a, dig_b;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    dig_a   = sa_q[WIDTH-1 -: DIGIT];
    dig_b   = sb_q[WIDTH-1 -: DIGIT];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Flipping both sign bits turns a signed compare into an unsigned one.
          sa_d    = bus.A ^ (bus.signed_mode ? MSB_MASK : '0);
          sb_d    = bus.B ^ (bus.signed_mode ? MSB_MASK : '0);
          cnt_d   = CNT_LOAD;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (dig_a != dig_b) begin
          eq_d    = 1'b0;
          gt_d    = (dig_a > dig_b);
          lt_d    = (dig_a < dig_b);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sa_d  = WIDTH'(sa_q << DIGIT);
          sb_d  = WIDTH'(sb_q << DIGIT);
          cnt_d = CW'(cnt_q - CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COMPARE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.AequalsB  = eq_q;
  assign bus.AgreaterB = gt_q;
  assign bus.AlessB    = lt_q;
endmodule
